// File: rtl/usb_cmd_responder.sv
// Command engine between the ISP1362 bridge FIFOs: decodes ping / register write /
// register read / echo frames and returns response frames; register file is exported.
module usb_cmd_responder #(
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          usb_read_en,
    input  logic [15:0]                   usb_read_data,
    input  logic                          usb_read_wait,
    output logic                          usb_write_en,
    output logic [15:0]                   usb_write_data,
    input  logic                          usb_write_wait,
    output logic [16*(2**ADDR_W)-1:0]     regs,
    output logic                          busy,
    output logic [7:0]                    err_count
);

    localparam int NREGS = 2**ADDR_W;
    localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [7:0] SYNC_IN   = 8'hA5;
    localparam logic [7:0] SYNC_OUT  = 8'h5A;
    localparam logic [7:0] OP_PING   = 8'h00;
    localparam logic [7:0] OP_WR     = 8'h01;
    localparam logic [7:0] OP_RD     = 8'h02;
    localparam logic [7:0] OP_ECHO   = 8'h03;
    localparam logic [7:0] HDR_BADOP = 8'hFF;
    localparam logic [7:0] HDR_BADAD = 8'hFE;

    typedef enum logic [2:0] {
        S_HDR, S_ARG, S_DATA, S_RSP0, S_RSP1, S_ERD, S_EWR
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         count_q, count_d;
    logic [15:0]         pay_q, pay_d;
    logic                wr_en_q, wr_en_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic [7:0]          err_q, err_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [15:0]         regs_q [NREGS];
    logic [15:0]         regs_d [NREGS];

    logic rd_ok, wr_ok, arg_ok, addr_ok, err_inc;

    assign usb_read_en = (state_q == S_HDR) || (state_q == S_ARG) ||
                         (state_q == S_DATA) || (state_q == S_ERD);
    assign rd_ok   = usb_read_en && !usb_read_wait;
    assign wr_ok   = wr_en_q && !usb_write_wait;
    assign arg_ok  = 32'(usb_read_data) < NREGS;
    assign addr_ok = 32'(addr_q) < NREGS;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        count_d   = count_q;
        pay_d     = pay_q;
        wr_en_d   = wr_en_q;
        wr_data_d = wr_data_q;
        regs_d    = regs_q;
        tmo_d     = '0;
        err_inc   = 1'b0;

        case (state_q)
            S_HDR: if (rd_ok) begin
                if (usb_read_data[15:8] != SYNC_IN) begin
                    err_inc = 1'b1;
                end else begin
                    op_d = usb_read_data[7:0];
                    case (usb_read_data[7:0])
                        OP_PING: begin
                            state_d   = S_RSP0;
                            wr_en_d   = 1'b1;
                            wr_data_d = {SYNC_OUT, OP_PING};
                            pay_d     = 16'h1362;
                        end
                        OP_WR, OP_RD, OP_ECHO: state_d = S_ARG;
                        default: begin
                            state_d   = S_RSP0;
                            wr_en_d   = 1'b1;
                            wr_data_d = {SYNC_OUT, HDR_BADOP};
                            pay_d     = {8'h00, usb_read_data[7:0]};
                            err_inc   = 1'b1;
                        end
                    endcase
                end
            end
            S_ARG: if (rd_ok) begin
                addr_d  = usb_read_data;
                case (op_q)
                    OP_WR: state_d = S_DATA;
                    OP_RD: begin
                        state_d = S_RSP0;
                        wr_en_d = 1'b1;
                        if (arg_ok) begin
                            wr_data_d = {SYNC_OUT, OP_RD};
                            pay_d     = regs_q[usb_read_data[ADDR_W-1:0]];
                        end else begin
                            wr_data_d = {SYNC_OUT, HDR_BADAD};
                            pay_d     = usb_read_data;
                            err_inc   = 1'b1;
                        end
                    end
                    default: begin
                        count_d   = usb_read_data;
                        state_d   = S_RSP0;
                        wr_en_d   = 1'b1;
                        wr_data_d = {SYNC_OUT, OP_ECHO};
                        pay_d     = usb_read_data;
                    end
                endcase
            end
            S_DATA: if (rd_ok) begin
                state_d = S_RSP0;
                wr_en_d = 1'b1;
                pay_d   = addr_q;
                if (addr_ok) begin
                    regs_d[addr_q[ADDR_W-1:0]] = usb_read_data;
                    wr_data_d = {SYNC_OUT, OP_WR};
                end else begin
                    wr_data_d = {SYNC_OUT, HDR_BADAD};
                    err_inc   = 1'b1;
                end
            end
            S_RSP0: if (wr_ok) begin
                wr_data_d = pay_q;
                state_d   = S_RSP1;
            end
            S_RSP1: if (wr_ok) begin
                wr_en_d = 1'b0;
                state_d = (op_q == OP_ECHO && count_q != 16'd0) ? S_ERD : S_HDR;
            end
            S_ERD: if (rd_ok) begin
                wr_en_d   = 1'b1;
                wr_data_d = usb_read_data;
                state_d   = S_EWR;
            end
            S_EWR: if (wr_ok) begin
                wr_en_d = 1'b0;
                count_d = count_q - 16'd1;
                state_d = (count_q == 16'd1) ? S_HDR : S_ERD;
            end
            default: state_d = S_HDR;
        endcase

        // Only read stalls inside a frame are bounded; the bridge may hold writes off indefinitely.
        if (TIMEOUT != 0 && !rd_ok &&
            (state_q == S_ARG || state_q == S_DATA || state_q == S_ERD)) begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_d == TMO_W'(TIMEOUT)) begin
                state_d = S_HDR;
                tmo_d   = '0;
                err_inc = 1'b1;
            end
        end

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HDR;
            op_q      <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            pay_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            err_q     <= '0;
            tmo_q     <= '0;
            // NOTE: the register file is tiny and visible to fabric logic, so it is reset like any flop.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            pay_q     <= pay_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            regs_q    <= regs_d;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regs
        assign regs[16*g +: 16] = regs_q[g];
    end

    assign usb_write_en   = wr_en_q;
    assign usb_write_data = wr_data_q;
    assign busy           = (state_q != S_HDR);
    assign err_count      = err_q;

endmodule
